// File: rtl/bist_engine_param.sv
// bist_engine_param: logic-BIST engine (LFSR stimulus, MISR compaction, golden compare); BIST_RESEED_EN reloads the LFSR with SEED2 at mid-run
module bist_engine_param #(
  parameter int                 LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 8'h1D,
  parameter logic [LFSR_W-1:0]  SEED       = 8'h01,
  parameter int                 MISR_W     = 21,
  parameter logic [MISR_W-1:0]  MISR_TAPS  = 21'h000005,
  parameter int                 N_IN       = 3,
  parameter int                 N_OUT      = 3,
  parameter int                 N_PATTERNS = 16,
  parameter int                 SCAN_LEN   = 8,
  parameter logic [MISR_W-1:0]  GOLDEN     = 21'h0,
  parameter logic [LFSR_W-1:0]  SEED2      = 8'h5A
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bist_start,
  input  logic [N_IN-1:0]   func_in,
  input  logic [N_OUT-1:0]  cut_resp,
  output logic [N_IN-1:0]   cut_in,
  output logic              scan_en,
  output logic              scan_in,
  output logic              bist_running,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature
);
  localparam int SW = $clog2(SCAN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [LFSR_W-1:0] SEED_NZ  = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [LFSR_W-1:0] SEED2_NZ = (SEED2 == '0) ? LFSR_W'(1) : SEED2;
  typedef enum logic [2:0] {S_IDLE, S_SEED, S_SHIFT, S_CAPTURE, S_COMPARE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [MISR_W-1:0] misr_q, misr_d, misr_step;
  logic [SW-1:0] shift_q, shift_d;
  logic [PW-1:0] pat_q, pat_d, pat_inc;
  logic pf_q, pf_d, sen_q, sen_d, run_q, run_d, end_q, end_d;
  logic last_shift, last_pat, reseed;
  // next-state, datapath steps and registered output decode
  always_comb begin
    lfsr_step = {lfsr_q[LFSR_W-2:0], 1'b0} ^ (lfsr_q[LFSR_W-1] ? LFSR_TAPS : '0);
    misr_step = {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_TAPS : '0) ^ MISR_W'(cut_resp);
    pat_inc = pat_q + PW'(1);
    last_shift = shift_q == SW'(SCAN_LEN - 1);
    last_pat = pat_inc == PW'(N_PATTERNS);
`ifdef BIST_RESEED_EN
    reseed = (N_PATTERNS >= 2) && (pat_inc == PW'(N_PATTERNS / 2));
`else
    reseed = 1'b0;
`endif
    state_d = state_q;
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    shift_d = shift_q;
    pat_d = pat_q;
    pf_d = pf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = bist_start ? S_SEED : state_q;
        pf_d = bist_start ? 1'b0 : pf_q;
      end
      S_SEED: begin
        lfsr_d = SEED_NZ;
        misr_d = '0;
        shift_d = '0;
        pat_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        lfsr_d = lfsr_step;
        misr_d = misr_step;
        shift_d = shift_q + SW'(1);
        state_d = last_shift ? S_CAPTURE : S_SHIFT;
      end
      S_CAPTURE: begin
        lfsr_d = reseed ? SEED2_NZ : lfsr_step;
        misr_d = misr_step;
        pat_d = pat_inc;
        shift_d = '0;
        state_d = last_pat ? S_COMPARE : S_SHIFT;
      end
      S_COMPARE: begin
        pf_d = misr_q == GOLDEN;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    sen_d = state_d == S_SHIFT;
    run_d = state_d inside {S_SEED, S_SHIFT, S_CAPTURE, S_COMPARE};
    end_d = state_d == S_DONE;
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      lfsr_q <= '0;
      misr_q <= '0;
      shift_q <= '0;
      pat_q <= '0;
      pf_q <= 1'b0;
      sen_q <= 1'b0;
      run_q <= 1'b0;
      end_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      shift_q <= shift_d;
      pat_q <= pat_d;
      pf_q <= pf_d;
      sen_q <= sen_d;
      run_q <= run_d;
      end_q <= end_d;
    end
  end
  assign cut_in = run_q ? lfsr_q[N_IN-1:0] : func_in;
  assign scan_in = lfsr_q[0];
  assign scan_en = sen_q;
  assign bist_running = run_q;
  assign bist_end = end_q;
  assign pass_fail = pf_q;
  assign signature = misr_q;
endmodule

// File: tb/tb_bist_engine_param.sv
// tb_bist_engine_param: random and directed checks of bist_engine_param against a run-index behavioural model
module tb_bist_engine_param;
  localparam int LW = 4, MW = 21, NI = 4, NO = 3, NP = 4, SL = 3;
  localparam int RUN = 2 + NP * (SL + 1);
  localparam logic [LW-1:0] TAPS = 4'h3, SD = 4'h1, SD2 = 4'hA;
  localparam logic [MW-1:0] MTAPS = 21'h000005, GOLD = 21'h0;
`ifdef BIST_RESEED_EN
  localparam bit RESEED = 1'b1;
  logic [3:0] seq_lit [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1, 4'h2};
`else
  localparam bit RESEED = 1'b0;
  logic [3:0] seq_lit [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
`endif
  bit sen_lit [RUN] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
  logic clk = 1'b0, rst = 1'b1, bist_start = 1'b0;
  logic [NI-1:0] func_in = '0;
  logic [NO-1:0] cut_resp = '0;
  logic [NI-1:0] cut_in;
  logic scan_en, scan_in, bist_running, bist_end, pass_fail;
  logic [MW-1:0] signature;
  logic [NO-1:0] rs [RUN];
  logic [MW-1:0] ref_sig;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;
  int m_t = -1;
  logic [LW-1:0] m_l = '0;
  logic [MW-1:0] m_m = '0;
  bit m_pf = 1'b0, m_done = 1'b0;

  always #5 clk = ~clk;

  bist_engine_param #(
    .LFSR_W(LW), .LFSR_TAPS(TAPS), .SEED(SD), .MISR_W(MW), .MISR_TAPS(MTAPS),
    .N_IN(NI), .N_OUT(NO), .N_PATTERNS(NP), .SCAN_LEN(SL), .GOLDEN(GOLD), .SEED2(SD2)
  ) dut (
    .CLK(clk), .RST(rst), .bist_start(bist_start), .func_in(func_in), .cut_resp(cut_resp),
    .cut_in(cut_in), .scan_en(scan_en), .scan_in(scan_in), .bist_running(bist_running),
    .bist_end(bist_end), .pass_fail(pass_fail), .signature(signature)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [LW-1:0] lstep(input logic [LW-1:0] l);
    return {l[LW-2:0], 1'b0} ^ (l[LW-1] ? TAPS : '0);
  endfunction

  function automatic logic [MW-1:0] mstep(input logic [MW-1:0] m, input logic [NO-1:0] r);
    return {m[MW-2:0], 1'b0} ^ (m[MW-1] ? MTAPS : '0) ^ MW'(r);
  endfunction

  // model: m_t is the cycle index within a run (0 = seed, 1..RUN-2 = scan/capture, RUN-1 = compare), -1 when idle/done
  always @(posedge clk) begin
    int k, pat;
    if (rst) begin
      m_t = -1; m_l = '0; m_m = '0; m_pf = 1'b0; m_done = 1'b0;
    end else if (m_t < 0) begin
      if (bist_start) begin m_t = 0; m_pf = 1'b0; m_done = 1'b0; end
    end else if (m_t == 0) begin
      m_l = SD; m_m = '0; m_t = 1;
    end else if (m_t < RUN - 1) begin
      k = m_t - 1;
      pat = k / (SL + 1) + 1;
      m_m = mstep(m_m, cut_resp);
      m_l = (RESEED && NP >= 2 && k % (SL + 1) == SL && pat == NP / 2) ? SD2 : lstep(m_l);
      m_t++;
    end else begin
      m_pf = (m_m == GOLD); m_done = 1'b1; m_t = -1;
    end
  end

  // compare every output against the model on each falling edge
  always @(negedge clk) begin
    bit run, sen;
    if (chk_en) begin
      run = m_t >= 0;
      sen = m_t >= 1 && m_t <= RUN - 2 && (m_t - 1) % (SL + 1) != SL;
      chk("bist_running", bist_running, run);
      chk("scan_en", scan_en, sen);
      chk("scan_in", scan_in, m_l[0]);
      chk("cut_in", cut_in, run ? m_l : func_in);
      chk("bist_end", bist_end, m_done);
      chk("pass_fail", pass_fail, m_pf);
      chk("signature", signature, m_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_pattern(input bit lit);
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    for (int t = 0; t < RUN; t++) begin
      cut_resp = rs[t];
      func_in = NI'($urandom);
      #1;
      if (t == 0) chk("seed_clears_end_pf", {bist_end, pass_fail}, 2'b00);
      if (lit) begin
        chk("lit_running", bist_running, 1'b1);
        chk("lit_scan_en", scan_en, sen_lit[t]);
        if (t >= 1 && t <= 16) chk("lit_lfsr_seq", cut_in, seq_lit[t-1]);
      end
      step();
    end
    #1;
    chk("end_after_compare", {bist_end, bist_running}, 2'b10);
  endtask

  initial begin
    repeat (3) begin
      func_in = NI'($urandom);
      step();
    end
    chk_en = 1'b1;
    #1;
    chk("reset_outputs", {bist_running, bist_end, pass_fail, scan_en, scan_in}, 5'b0);
    chk("reset_signature", signature, 21'h0);
    rst = 1'b0;
    for (int t = 0; t < RUN; t++) rs[t] = '0;
    run_pattern(1'b1);
    chk("zero_resp_pass", pass_fail, 1'b1);
    chk("zero_resp_sig", signature, 21'h0);
    step();
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    #1;
    chk("midrun_reset", {bist_running, bist_end, pass_fail, scan_en, scan_in}, 5'b0);
    chk("midrun_reset_sig", signature, 21'h0);
    rst = 1'b0;
    step();
    run_pattern(1'b1);
    chk("after_reset_pass", pass_fail, 1'b1);
    for (int t = 0; t < RUN; t++) rs[t] = NO'($urandom);
    step();
    run_pattern(1'b0);
    ref_sig = m_m;
    rs[2] = rs[2] ^ 3'b001;
    step();
    run_pattern(1'b0);
    chk("flip_sig_differs", signature != ref_sig, 1'b1);
    chk("flip_pf", pass_fail, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      bist_start = ($urandom % 6) == 0;
      rst = ($urandom % 200) == 0;
      cut_resp = NO'($urandom);
      func_in = NI'($urandom);
      step();
    end
    rst = 1'b0;
    bist_start = 1'b0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
